perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter N_IN, default 7: number of binary input features, range 2..32.
REQ-002 SHALL have parameter W, default 8: signed two's-complement width of weights and threshold, range 4..16.
REQ-003 SHALL have parameter LR_SHIFT, default 0: learning step is 1<<LR_SHIFT, with LR_SHIFT < W-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a sample is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a sample.
REQ-008 SHALL have port in, input, N_IN bits: feature vector, bit i = x[i].
REQ-009 SHALL have port threshold, input, W bits, signed: activation threshold.
REQ-010 SHALL have port train, input, 1 bit: 1 = train, 0 = infer.
REQ-011 SHALL have port exp_res, input, 1 bit: expected class, 1 = +1, 0 = -1.
REQ-012 SHALL have port clr_cnt, input, 1 bit: synchronously clears err_cnt.
REQ-013 SHALL have port out_valid, output, 1 bit: one-cycle result strobe.
REQ-014 SHALL have port result, output, 2 bits: 2'b01 = +1, 2'b11 = -1.
REQ-015 SHALL have port err, output, 1 bit: misclassification flag, valid with out_valid.
REQ-016 SHALL have port err_cnt, output, 16 bits: count of training errors.

Function
REQ-017 SHALL hold N_IN signed W-bit weights and use an accumulator of W+clog2(N_IN+1) bits, so the accumulator never overflows.
REQ-018 SHALL run a 4-state FSM with states IDLE, ACC, DECIDE and UPDATE.
REQ-019 SHALL drive in_ready high only in IDLE; a handshake is in_valid&&in_ready.
REQ-020 SHALL, on the handshake edge, latch in, threshold, train and exp_res, clear the accumulator, set the index to 0 and move to ACC.
REQ-021 SHALL, in ACC, add sign-extended w[idx] when x[idx]=1 on each edge, for N_IN edges, then move to DECIDE.
REQ-022 SHALL, on the DECIDE edge, register result = +1 if acc >= sign-extended threshold, else -1; pulse out_valid for exactly one cycle; and set err = (result != expected), forced to 0 in infer mode.
REQ-023 SHALL make out_valid rise exactly N_IN+1 edges after the accepting edge.
REQ-024 SHALL leave DECIDE for UPDATE if train&&err, otherwise for IDLE.
REQ-025 SHALL, in UPDATE, do w[idx] += (exp?+1:-1)*(1<<LR_SHIFT) when x[idx]=1 on each edge, for N_IN edges, then return to IDLE.
REQ-026 SHALL hold result and err between strobes.
REQ-027 SHALL have no output backpressure.
REQ-028 SHALL increment err_cnt on each training error and saturate it at 16'hFFFF.
REQ-029 SHALL give clr_cnt priority over a simultaneous increment, leaving err_cnt = 0.
REQ-030 SHALL ignore in_valid while not in IDLE, without latching data.

Reset
REQ-031 SHALL, on reset low at any time including mid-ACC or mid-UPDATE, immediately force: state IDLE; all weights 0; accumulator and index 0; result 2'b00; out_valid 0; err 0; err_cnt 0.
REQ-032 SHALL drive in_ready high from the first edge after reset is released.

Configuration
REQ-033 SHALL, when PERCEPTRON_TRAINER_SAT_EN is defined, clamp weight updates to [-2^(W-1), 2^(W-1)-1].
REQ-034 SHALL, when PERCEPTRON_TRAINER_SAT_EN is undefined, let weight updates wrap modulo 2^W.

Structure
REQ-035 SHALL place the FSM state enum, the result encodings RES_POS=2'b01 and RES_NEG=2'b11, and the accumulator-width function in a package named perceptron_pkg.
REQ-036 SHALL use one sub-module, perceptron_wupd: a combinational signed add of the step, with optional saturation.

Verification (N_IN=7, W=8)
REQ-037 SHALL cover: after reset, infer in=7'h7F, threshold=0 -> result=2'b01 and err=0 at edge 8; in_ready low for edges 1-8, high from edge 9.
REQ-038 SHALL cover: train in=7'h01, threshold=1, exp_res=1 -> result=2'b11, err=1, err_cnt=1, w[0]=1; in_ready high 16 edges after accept; a repeat infer gives result=2'b01.
REQ-039 SHALL cover: LR_SHIFT=2, threshold=127, in=7'h01, exp_res=1, trained 40 times -> with SAT_EN: w[0]=127 and err_cnt=32; without: w[0]=-128 after the 32nd training and errors continue (err_cnt=40).
REQ-040 SHALL cover: reset asserted on the 3rd UPDATE cycle -> all outputs and weights 0 immediately, in_ready=1 after release.
REQ-041 SHALL cover: in_valid held high across a busy period with the vector changed mid-busy -> only the vector present at the in_ready handshake is processed, one out_valid per handshake.
REQ-042 SHALL cover: clr_cnt asserted on an error DECIDE edge -> err_cnt=0.

Source files
------------

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: shared definitions for the perceptron trainer.
// Holds the FSM state type, the two-bit result encodings and the
// helper that sizes the dot-product accumulator.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        DECIDE = 2'd2,
        UPDATE = 2'd3
    } state_e;

    localparam logic [1:0] RES_POS = 2'b01;
    localparam logic [1:0] RES_NEG = 2'b11;

    // Worst-case sum of n_in weights of width w needs clog2(n_in+1) guard bits.
    function automatic int acc_width(input int w, input int n_in);
        return w + $clog2(n_in + 1);
    endfunction

endpackage

// File: rtl/perceptron_wupd.sv
// perceptron_wupd: combinational weight update w +/- (1 << LR_SHIFT).
// Optional macro PERCEPTRON_TRAINER_SAT_EN: clamp the result to the signed
// W-bit range instead of wrapping modulo 2^W.
module perceptron_wupd
    import perceptron_pkg::*;
#(
    parameter int W        = 8,
    parameter int LR_SHIFT = 0
) (
    input  logic signed [W-1:0] w_i,
    input  logic                pos_i,
    output logic signed [W-1:0] w_o
);

`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam logic signed [W:0] STEP = (W+1)'(1) << LR_SHIFT;

    logic signed [W:0] sum;

    // Add or subtract the step one bit wider so an overflow shows in the top bits.
    always_comb begin
        if (pos_i) sum = (W+1)'(w_i) + STEP;
        else       sum = (W+1)'(w_i) - STEP;
    end

    // Top two bits disagree only on overflow; the carry bit tells the direction.
    always_comb begin
        if (sum[W] != sum[W-1]) begin
            w_o = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            w_o = sum[W-1:0];
        end
    end
`else
    localparam logic signed [W-1:0] STEP = W'(1) << LR_SHIFT;

    // Plain W-bit arithmetic: overflow wraps in two's complement.
    always_comb begin
        if (pos_i) w_o = w_i + STEP;
        else       w_o = w_i - STEP;
    end
`endif

endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: serial perceptron with online training.
// One feature per cycle is accumulated (ACC), the sum is compared with the
// threshold (DECIDE) and, on a training error, weights of active features
// are nudged toward the expected class (UPDATE).
// Optional macro PERCEPTRON_TRAINER_SAT_EN selects saturating weight updates.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN     = 7,
    parameter int W        = 8,
    parameter int LR_SHIFT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_IN-1:0]     in,
    input  logic signed [W-1:0] threshold,
    input  logic                train,
    input  logic                exp_res,
    input  logic                clr_cnt,
    output logic                out_valid,
    output logic [1:0]          result,
    output logic                err,
    output logic [15:0]         err_cnt
);

    localparam int AW = acc_width(W, N_IN);
    localparam int IW = $clog2(N_IN);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    state_e               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [W-1:0]  w_q [N_IN];
    logic signed [W-1:0]  w_new;
    logic                 w_wr;
    logic                 capture;
    logic                 dec_pos;

    logic [N_IN-1:0]      x_q;
    logic signed [W-1:0]  thr_q;
    logic                 train_q;
    logic                 exp_q;

    logic [1:0]           result_q, result_d;
    logic                 err_q, err_d;
    logic                 out_valid_q, out_valid_d;
    logic [15:0]          err_cnt_q, err_cnt_d;

    // Candidate new value for the currently indexed weight.
    perceptron_wupd #(
        .W        (W),
        .LR_SHIFT (LR_SHIFT)
    ) u_wupd (
        .w_i   (w_q[idx_q]),
        .pos_i (exp_q),
        .w_o   (w_new)
    );

    // Next-state, datapath control and output decode.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        result_d    = result_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        w_wr        = 1'b0;
        capture     = 1'b0;
        dec_pos     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (x_q[idx_q]) acc_d = acc_q + AW'(w_q[idx_q]);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DECIDE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DECIDE: begin
                dec_pos     = (acc_q >= AW'(thr_q));
                result_d    = dec_pos ? RES_POS : RES_NEG;
                err_d       = train_q && (dec_pos != exp_q);
                out_valid_d = 1'b1;
                if (err_d) begin
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    state_d = UPDATE;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                w_wr = x_q[idx_q];
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing wins over a same-cycle increment.
        if (clr_cnt) err_cnt_d = '0;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            result_q    <= 2'b00;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Weight file: cleared by reset, one entry written per UPDATE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
        end else if (w_wr) begin
            w_q[idx_q] <= w_new;
        end
    end

    // Sample operands only on the accepting handshake.
    always_ff @(posedge clk) begin
        if (capture) begin
            x_q     <= in;
            thr_q   <= threshold;
            train_q <= train;
            exp_q   <= exp_res;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed bench with a transaction-level model.
// Honors PERCEPTRON_TRAINER_SAT_EN for expected weight-update behaviour.
`timescale 1ns/1ps
module tb_perceptron_trainer;

    localparam int N_IN     = 7;
    localparam int W        = 8;
    localparam int LAT      = N_IN + 1;
    localparam int BUSY_TRN = 2 * N_IN + 1;
    localparam int WMAX     = 2 ** (W - 1) - 1;
    localparam int WMIN     = -(2 ** (W - 1));
`ifdef PERCEPTRON_TRAINER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic                in_valid = 1'b0;
    logic [N_IN-1:0]     in_vec   = '0;
    logic signed [W-1:0] thr      = '0;
    logic                train    = 1'b0;
    logic                exp_res  = 1'b0;
    logic                clr_cnt  = 1'b0;
    logic                in_ready, out_valid, err;
    logic [1:0]          result;
    logic [15:0]         err_cnt;

    logic                in_valid2 = 1'b0;
    logic [N_IN-1:0]     in_vec2   = '0;
    logic signed [W-1:0] thr2      = '0;
    logic                train2    = 1'b0;
    logic                exp2      = 1'b0;
    logic                in_ready2, out_valid2, err2;
    logic [1:0]          result2;
    logic [15:0]         err_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    perceptron_trainer #(.N_IN(N_IN), .W(W), .LR_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in(in_vec), .threshold(thr), .train(train), .exp_res(exp_res),
        .clr_cnt(clr_cnt), .out_valid(out_valid), .result(result), .err(err),
        .err_cnt(err_cnt)
    );

    perceptron_trainer #(.N_IN(N_IN), .W(W), .LR_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in(in_vec2), .threshold(thr2), .train(train2), .exp_res(exp2),
        .clr_cnt(1'b0), .out_valid(out_valid2), .result(result2), .err(err2),
        .err_cnt(err_cnt2)
    );

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // ---------------- transaction-level model of dut ----------------
    int          m_w [N_IN];
    int          m_cnt  = 0;
    int          m_busy = 0;
    int          m_ec   = 0;
    bit          m_ov   = 1'b0;
    bit          m_err  = 1'b0;
    logic [1:0]  m_res  = 2'b00;
    bit          p_pos, p_err, p_exp;
    logic [N_IN-1:0] p_x;

    function automatic int upd(input int w, input bit pos, input int lr);
        int v;
        v = pos ? w + (1 << lr) : w - (1 << lr);
        if (v > WMAX) v = SAT ? WMAX : v - (1 << W);
        if (v < WMIN) v = SAT ? WMIN : v + (1 << W);
        return v;
    endfunction

    initial begin
        foreach (m_w[i]) m_w[i] = 0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                foreach (m_w[i]) m_w[i] = 0;
                m_cnt = 0; m_busy = 0; m_ec = 0;
                m_ov = 1'b0; m_err = 1'b0; m_res = 2'b00;
            end else begin
                m_ov = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_ov  = 1'b1;
                        m_res = p_pos ? 2'b01 : 2'b11;
                        m_err = p_err;
                        if (p_err) begin
                            if (m_ec < 65535) m_ec++;
                            for (int i = 0; i < N_IN; i++)
                                if (p_x[i]) m_w[i] = upd(m_w[i], p_exp, 0);
                        end
                    end
                end
                if (clr_cnt) m_ec = 0;
                if (m_busy > 0) begin
                    m_busy--;
                end else if (in_valid) begin
                    int s;
                    s = 0;
                    for (int i = 0; i < N_IN; i++) if (in_vec[i]) s += m_w[i];
                    p_pos  = (s >= int'(thr));
                    p_err  = train && (p_pos != exp_res);
                    p_x    = in_vec;
                    p_exp  = exp_res;
                    m_cnt  = LAT;
                    m_busy = p_err ? BUSY_TRN : LAT;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of dut against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("cyc_out_valid", int'(out_valid), int'(m_ov));
                check("cyc_result", int'(result), int'(m_res));
                check("cyc_err", int'(err), int'(m_err));
                check("cyc_err_cnt", int'(err_cnt), m_ec);
                check("cyc_in_ready", int'(in_ready), int'(m_busy == 0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [N_IN-1:0] x, input int t, input bit tr, input bit e);
        int k;
        @(negedge clk);
        in_vec = x; thr = W'(t); train = tr; exp_res = e; in_valid = 1'b1;
        for (k = 0; k < 60; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check("send_accept", int'(k < 60), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send2(input logic [N_IN-1:0] x, input int t, input bit tr, input bit e);
        int k;
        @(negedge clk);
        in_vec2 = x; thr2 = W'(t); train2 = tr; exp2 = e; in_valid2 = 1'b1;
        for (k = 0; k < 60; k++) begin
            if (in_ready2) break;
            @(negedge clk);
        end
        check("send2_accept", int'(k < 60), 1);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    initial begin
        int  pulses;
        bit  drop;
        int  rec_res [4];
        int  rec_err [4];
        int  k2;

        // Reset and reset-state outputs
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);

        // Infer all-ones vector with zero weights and threshold 0 -> +1
        send(7'h7F, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_ready_low", int'(in_ready), 0);
            check("t1_no_strobe", int'(out_valid), 0);
        end
        @(negedge clk);
        check("t1_ready_high", int'(in_ready), 1);
        check("t1_out_valid", int'(out_valid), 1);
        check("t1_result", int'(result), 1);
        check("t1_err", int'(err), 0);
        @(negedge clk);
        check("t1_strobe_one_cycle", int'(out_valid), 0);

        // Training error on x0, threshold 1, expect +1
        send(7'h01, 1, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 9) begin
                check("t2_out_valid", int'(out_valid), 1);
                check("t2_result", int'(result), 3);
                check("t2_err", int'(err), 1);
                check("t2_err_cnt", int'(err_cnt), 1);
            end
            if (k == 15) check("t2_ready_low15", int'(in_ready), 0);
            if (k == 16) check("t2_ready_high16", int'(in_ready), 1);
        end
        check("t2_w0", int'(dut.w_q[0]), 1);
        check("t2_model_w0", m_w[0], 1);
        send(7'h01, 1, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("t2_reinfer_valid", int'(out_valid), 1);
        check("t2_reinfer_result", int'(result), 1);
        check("t2_reinfer_err", int'(err), 0);

        // in_valid held through a busy period, vector changed mid-busy
        @(negedge clk);
        in_vec = 7'h03; thr = 8'sd5; train = 1'b1; exp_res = 1'b1; in_valid = 1'b1;
        pulses = 0; drop = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) begin
                if (pulses < 4) begin
                    rec_res[pulses] = int'(result);
                    rec_err[pulses] = int'(err);
                end
                pulses++;
            end
            if (drop) begin
                in_valid = 1'b0; in_vec = 7'h7F; drop = 1'b0;
            end
            if (k == 4) begin
                in_vec = 7'h02; thr = 8'sd2; train = 1'b0; exp_res = 1'b0;
            end
            if (k >= 4 && in_valid && in_ready) drop = 1'b1;
        end
        check("t3_pulses", pulses, 2);
        check("t3_a_result", rec_res[0], 3);
        check("t3_a_err", rec_err[0], 1);
        check("t3_b_result", rec_res[1], 3);
        check("t3_b_err", rec_err[1], 0);
        check("t3_err_cnt", int'(err_cnt), 2);
        check("t3_w1", int'(dut.w_q[1]), 1);

        // clr_cnt on the error DECIDE edge
        send(7'h01, 10, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 8) clr_cnt = 1'b1;
        end
        @(negedge clk);
        clr_cnt = 1'b0;
        check("t4_out_valid", int'(out_valid), 1);
        check("t4_err", int'(err), 1);
        check("t4_err_cnt_cleared", int'(err_cnt), 0);
        repeat (8) @(negedge clk);
        check("t4_w0", int'(dut.w_q[0]), 3);

        // Reset asserted during the third UPDATE cycle
        send(7'h7F, 100, 1'b1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 9) check("t5_err_before", int'(err), 1);
        end
        reset = 1'b0;
        #1;
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_result", int'(result), 0);
        check("t5_err", int'(err), 0);
        check("t5_err_cnt", int'(err_cnt), 0);
        for (int i = 0; i < N_IN; i++) check("t5_weight_zero", int'(dut.w_q[i]), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_ready_after_release", int'(in_ready), 1);

        // LR_SHIFT=2 instance trained 40 times toward +1 against threshold 127
        for (int t = 1; t <= 40; t++) begin
            send2(7'h01, 127, 1'b1, 1'b1);
            for (k2 = 0; k2 < 20; k2++) begin
                @(negedge clk);
                if (out_valid2) break;
            end
            check("t6_strobe", int'(k2 < 20), 1);
            check("t6_err", int'(err2), int'(SAT ? (t <= 32) : 1'b1));
            check("t6_result", int'(result2), (SAT ? (t <= 32) : 1'b1) ? 3 : 1);
            for (k2 = 0; k2 < 20; k2++) begin
                if (in_ready2) break;
                @(negedge clk);
            end
            if (t == 32) check("t6_w0_after32", int'(dut2.w_q[0]), SAT ? 127 : -128);
        end
        check("t6_err_cnt", int'(err_cnt2), SAT ? 32 : 40);
        check("t6_w0_final", int'(dut2.w_q[0]), SAT ? 127 : -96);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
